uart_word_sender: RTL
=====================

Name: uart_word_sender

Overview:
Reverse direction of the UART word capture path. On a start pulse, reads a run of 16-bit words from a 32-entry word table through a synchronous-address read port. It pushes each word into the UART transmit FIFO as bytes, high byte first. Sits between the word table and the uart block's wr_uart/w_data/tx_full interface.

Parameters:
DEPTH, 32, number of words in the table
ADDR_BITS, 5, table address width (DEPTH = 2**ADDR_BITS)
GAP_CYCLES, 10, minimum clk cycles from one wr_uart pulse to the next; legal range 1..255

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request; sampled only in IDLE
start_addr  input  ADDR_BITS  first word address
word_count  input  ADDR_BITS+1  words to send, 0..32
rd_addr  output  ADDR_BITS  table read address, registered
rd_data  input  16  table word at rd_addr, combinational from table
tx_full  input  1  UART TX FIFO full
wr_uart  output  1  one-cycle FIFO write strobe, registered
w_data  output  8  byte to write, valid while wr_uart=1
busy  output  1  transfer in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, immediate): state IDLE; rd_addr=0, wr_uart=0, w_data=0, busy=0, done=0; internal counters and word register cleared.
- FSM states: IDLE, FETCH, SEND, GAP, NEXT, FINISH.
- IDLE: start=1 and word_count!=0 -> FETCH. Same edge: rd_addr<=start_addr, remaining<=word_count, busy<=1.
- IDLE: start=1 and word_count=0 -> FINISH. No writes occur.
- FETCH: one cycle. word_q<=rd_data; byte index<=0. Next state SEND.
- SEND: if tx_full=0, next cycle wr_uart=1 with w_data=selected byte and gap counter loaded; next state GAP.
- SEND: if tx_full=1, stall indefinitely. No strobe, byte held, nothing dropped.
- Byte order per word: index 0 = word_q[15:8], index 1 = word_q[7:0].
- GAP: wr_uart=1 for exactly its first cycle only.
- GAP: wait until GAP_CYCLES cycles have elapsed since the strobe.
- GAP exit: if bytes remain in the word, index+1 and go to SEND.
- GAP exit: else if remaining>1, go to NEXT.
- GAP exit: else go to FINISH.
- NEXT: rd_addr<=rd_addr+1, wrapping modulo DEPTH (31 -> 0); remaining<=remaining-1; next state FETCH.
- FINISH: done=1 for one cycle; busy=0 in that same cycle; next state IDLE.
- Latency: start at cycle 0 -> rd_addr valid cycle 1 -> first possible wr_uart at cycle 3 when tx_full=0.
- Strobe spacing: wr_uart pulses are never closer than GAP_CYCLES; a stall in SEND only lengthens spacing.
- start while busy: ignored. It is not queued.
- start_addr and word_count: sampled only at the accepting edge. Later changes have no effect.
- word_count=32: every entry is sent once, with wrap.
- Reset mid-transfer: strobe drops asynchronously; the partial word is abandoned; a following start behaves as from power-up.

Optional Feature:
UART_SENDER_ASCII_EN
- Defined: each word is sent as 6 bytes. Four uppercase ASCII hex digits come first, MSB nibble first: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46. Then 0x0D, 0x0A. The byte index runs 0..5.
- Not defined: raw 2-byte mode as above; no ASCII logic is synthesised.
- Handshake, gap and wrap rules are identical in both modes.

Test Plan:
- Raw, word 3 = 0xA55A, start_addr=3, word_count=1, tx_full=0 -> exactly two wr_uart pulses: 0xA5 then 0x5A, 10 cycles apart; done pulse; busy low.
- tx_full held 1 for 50 cycles on entering SEND -> no strobe during hold. One pulse carrying the pending byte after release; total byte count unchanged.
- start_addr=30, word_count=4, words 0x0102/0x0304/0x0506/0x0708 at 30/31/0/1 -> rd_addr 30,31,0,1. Bytes 01 02 03 04 05 06 07 08.
- word_count=0 -> done pulse with zero wr_uart pulses. A second start while busy during a 2-word run is ignored: exactly 4 bytes.
- Reset asserted mid-run after the first byte -> wr_uart, busy and rd_addr go to 0 immediately. A new start with addr=0, count=1 sends exactly 2 correct bytes.
- ASCII build, word 0x1F0B -> bytes 0x31,0x46,0x30,0x42,0x0D,0x0A, then done.

Source files
------------

// File: rtl/uart_word_sender.sv
// ---------------------------------------------------------------------------
// uart_word_sender
//
// Reads a run of 16-bit words from a word table (synchronous-address read
// port, combinational data) and pushes them into a UART transmit FIFO one
// byte at a time. Raw mode sends the high byte first, then the low byte. Strobes
// are always at least GAP_CYCLES apart. If the FIFO is full, the sender stalls
// without dropping anything.
//
// Build option: define UART_SENDER_ASCII_EN to send each word as four
// uppercase hex digits (MSB nibble first) followed by CR, LF.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   start       one-cycle request, only honoured while idle
//   start_addr  first table address (sampled on the accepting edge)
//   word_count  number of words to send, 0..DEPTH (sampled on accept)
//   rd_addr     registered table read address
//   rd_data     table word at rd_addr
//   tx_full     UART TX FIFO full
//   wr_uart     one-cycle FIFO write strobe
//   w_data      byte to write, valid while wr_uart is high
//   busy        transfer in progress
//   done        one-cycle completion pulse
// ---------------------------------------------------------------------------
module uart_word_sender #(
    parameter int DEPTH      = 32,
    parameter int ADDR_BITS  = 5,
    parameter int GAP_CYCLES = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] start_addr,
    input  logic [ADDR_BITS:0]   word_count,
    output logic [ADDR_BITS-1:0] rd_addr,
    input  logic [15:0]          rd_data,
    input  logic                 tx_full,
    output logic                 wr_uart,
    output logic [7:0]           w_data,
    output logic                 busy,
    output logic                 done
);

`ifdef UART_SENDER_ASCII_EN
    localparam int IDX_W = 3;
    localparam logic [IDX_W-1:0] LAST_IDX = 3'd5;
`else
    localparam int IDX_W = 1;
    localparam logic [IDX_W-1:0] LAST_IDX = 1'b1;
`endif

    // The GAP state lasts GAP_CYCLES-1 cycles and SEND adds one more cycle, so
    // the strobe-to-strobe spacing inside a word is exactly GAP_CYCLES.
    localparam logic [7:0] GAP_LOAD = 8'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND,
        GAP,
        NEXT,
        FINISH
    } state_t;

    state_t                 state_q;
    logic [ADDR_BITS-1:0]   rd_addr_q;
    logic [ADDR_BITS:0]     remaining_q;
    logic [15:0]            word_q;
    logic [IDX_W-1:0]       idx_q;
    logic [7:0]             gap_q;
    logic                   wr_uart_q;
    logic [7:0]             w_data_q;
    logic                   busy_q;
    logic                   done_q;
    logic [7:0]             byte_sel;

`ifdef UART_SENDER_ASCII_EN
    // One hex character per nibble of the latched word; index 0 is the
    // least significant nibble.
    logic [7:0] hex_char [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_hex
            logic [3:0] nib;
            assign nib          = word_q[4*gi +: 4];
            assign hex_char[gi] = (nib < 4'd10) ? {4'h3, nib}
                                                : (8'h37 + {4'h0, nib});
        end
    endgenerate

    always_comb begin
        byte_sel = 8'h0A;
        case (idx_q)
            3'd0:    byte_sel = hex_char[3];
            3'd1:    byte_sel = hex_char[2];
            3'd2:    byte_sel = hex_char[1];
            3'd3:    byte_sel = hex_char[0];
            3'd4:    byte_sel = 8'h0D;
            default: byte_sel = 8'h0A;
        endcase
    end
`else
    always_comb begin
        byte_sel = idx_q[0] ? word_q[7:0] : word_q[15:8];
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rd_addr_q   <= '0;
            remaining_q <= '0;
            word_q      <= '0;
            idx_q       <= '0;
            gap_q       <= '0;
            wr_uart_q   <= 1'b0;
            w_data_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // Both pulses last a single cycle unless they are re-armed below.
            wr_uart_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (word_count != '0) begin
                            rd_addr_q   <= start_addr;
                            remaining_q <= word_count;
                            busy_q      <= 1'b1;
                            state_q     <= FETCH;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= FINISH;
                        end
                    end
                end
                FETCH: begin
                    word_q  <= rd_data;
                    idx_q   <= '0;
                    state_q <= SEND;
                end
                SEND: begin
                    if (!tx_full) begin
                        wr_uart_q <= 1'b1;
                        w_data_q  <= byte_sel;
                        gap_q     <= GAP_LOAD;
                        state_q   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_q != 8'd0) begin
                        gap_q <= gap_q - 8'd1;
                    end else if (idx_q != LAST_IDX) begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= SEND;
                    end else if (remaining_q > (ADDR_BITS+1)'(1)) begin
                        state_q <= NEXT;
                    end else begin
                        // done and busy are registered, so they change in
                        // the same cycle that FINISH is occupied.
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= FINISH;
                    end
                end
                NEXT: begin
                    rd_addr_q   <= (rd_addr_q == ADDR_BITS'(DEPTH - 1)) ? '0
                                                                        : rd_addr_q + 1'b1;
                    remaining_q <= remaining_q - 1'b1;
                    state_q     <= FETCH;
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rd_addr = rd_addr_q;
    assign wr_uart = wr_uart_q;
    assign w_data  = w_data_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
